stream_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 32-bit stb/ack output stream (e.g. output_rs232_tx or output_eth_tx) between N independent producer processes.
- Each requester is a standard stb/ack word stream. The block serialises accepted words onto the single output and reports which requester owns each word.
- Sits between the user_design processes and the shared output pin/peripheral.

---
 rtl/stream_rr_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter
// Round-robin arbiter that serialises N stb/ack word streams onto one shared
// stb/ack output and reports which requester owns each outgoing word.
//
// Handshake: a word moves on a rising edge where stb and ack are both 1.
// Producers hold stb and data stable until acked; the consumer sees out_stb
// and out_data held until it returns out_ack. Every output is registered.
//
// Optional build macro STREAM_ARB_BURST_EN: lets the current owner keep the
// grant for up to BURST consecutive words while it keeps its stb asserted.
//
// dbg_state exposes the FSM state (0=IDLE, 1=ACCEPT, 2=SEND).
module stream_rr_arbiter #(
   parameter int N     = 4,
   parameter int W     = 32,
   parameter int BURST = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N*W-1:0]         in_data,
   input  logic [N-1:0]           in_stb,
   output logic [N-1:0]           in_ack,
   output logic [W-1:0]           out_data,
   output logic                   out_stb,
   input  logic                   out_ack,
   output logic [$clog2(N)-1:0]   out_grant,
   output logic [1:0]             dbg_state
);

   localparam int GW = $clog2(N);

   // Reject configurations outside the supported range at elaboration time.
   if (N < 2 || N > 8 || BURST < 1) begin : g_cfg_check
      $error("stream_rr_arbiter: unsupported N or BURST");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      SEND   = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [GW-1:0]   grant, grant_nxt;
   logic [GW-1:0]   last, last_nxt;
   logic [N-1:0]    ack_nxt;
   logic [W-1:0]    data_nxt;
   logic            stb_nxt;
   logic [GW-1:0]   ogrant_nxt;

   logic            found;
   logic [GW-1:0]   winner;
   logic [W-1:0]    gdata;

`ifdef STREAM_ARB_BURST_EN
   localparam int CW = $clog2(BURST + 1);
   logic [CW-1:0]   burst_cnt, cnt_nxt;
`endif

   assign dbg_state = state;

   function automatic logic [N-1:0] onehot(input logic [GW-1:0] g);
      logic [N-1:0] v;
      v    = '0;
      v[g] = 1'b1;
      return v;
   endfunction

   // Round-robin search: first set in_stb bit starting at last+1, wrapping at N-1 -> 0.
   always_comb begin
      int t;
      logic [GW-1:0] idx;
      found  = 1'b0;
      winner = '0;
      t      = 0;
      idx    = '0;
      for (int k = 0; k < N; k++) begin
         t = int'(last) + 1 + k;
         if (t >= N) t = t - N;
         idx = GW'(t);
         if (!found && in_stb[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // Select the data word of the currently granted requester.
   always_comb begin
      gdata = '0;
      for (int i = 0; i < N; i++) begin
         if (grant == GW'(i)) gdata = in_data[i*W +: W];
      end
   end

   // Next-state and next-output logic for the IDLE -> ACCEPT -> SEND cycle.
   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant;
      last_nxt   = last;
      ack_nxt    = in_ack;
      data_nxt   = out_data;
      stb_nxt    = out_stb;
      ogrant_nxt = out_grant;
`ifdef STREAM_ARB_BURST_EN
      cnt_nxt    = burst_cnt;
`endif
      case (state)
         IDLE: begin
            ack_nxt = '0;
            if (found) begin
               grant_nxt = winner;
               ack_nxt   = onehot(winner);
               state_nxt = ACCEPT;
`ifdef STREAM_ARB_BURST_EN
               cnt_nxt   = '0;
`endif
            end
         end
         ACCEPT: begin
            ack_nxt = onehot(grant);
            // A missing stb here is a producer protocol violation; just wait.
            if (in_stb[grant]) begin
               data_nxt   = gdata;
               ogrant_nxt = grant;
               ack_nxt    = '0;
               stb_nxt    = 1'b1;
               last_nxt   = grant;
               state_nxt  = SEND;
            end
         end
         SEND: begin
            ack_nxt = '0;
            stb_nxt = 1'b1;
            if (out_ack) begin
               stb_nxt = 1'b0;
`ifdef STREAM_ARB_BURST_EN
               if (in_stb[grant] && (burst_cnt < CW'(BURST - 1))) begin
                  cnt_nxt   = burst_cnt + CW'(1);
                  ack_nxt   = onehot(grant);
                  state_nxt = ACCEPT;
               end else begin
                  cnt_nxt   = '0;
                  last_nxt  = grant;
                  state_nxt = IDLE;
               end
`else
               state_nxt = IDLE;
`endif
            end
         end
         default: begin
            ack_nxt   = '0;
            stb_nxt   = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset discards any word held in SEND.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= '0;
         last      <= GW'(N - 1);
         in_ack    <= '0;
         out_data  <= '0;
         out_stb   <= 1'b0;
         out_grant <= '0;
`ifdef STREAM_ARB_BURST_EN
         burst_cnt <= '0;
`endif
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         last      <= last_nxt;
         in_ack    <= ack_nxt;
         out_data  <= data_nxt;
         out_stb   <= stb_nxt;
         out_grant <= ogrant_nxt;
`ifdef STREAM_ARB_BURST_EN
         burst_cnt <= cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter
// Directed bench for stream_rr_arbiter: a 4-requester instance covers
// latency, rotation, backpressure and reset; a 3-requester instance covers
// the non-power-of-two pointer wrap. Producers are modelled per requester as
// a count of words still to send with a fixed data word.
module tb_stream_rr_arbiter;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // ---------------- DUT, N=4 ----------------
   logic [127:0] in_data;
   logic [3:0]   in_stb;
   logic [3:0]   in_ack;
   logic [31:0]  out_data;
   logic         out_stb;
   logic         out_ack;
   logic [1:0]   out_grant;
   logic [1:0]   dbg_state;

   stream_rr_arbiter #(.N(4), .W(32), .BURST(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_stb    (in_stb),
      .in_ack    (in_ack),
      .out_data  (out_data),
      .out_stb   (out_stb),
      .out_ack   (out_ack),
      .out_grant (out_grant),
      .dbg_state (dbg_state)
   );

   // ---------------- DUT, N=3 ----------------
   logic [95:0]  in_data3;
   logic [2:0]   in_stb3;
   logic [2:0]   in_ack3;
   logic [31:0]  out_data3;
   logic         out_stb3;
   logic         out_ack3;
   logic [1:0]   out_grant3;
   logic [1:0]   dbg_state3;

   stream_rr_arbiter #(.N(3), .W(32), .BURST(4)) u_dut3 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data3),
      .in_stb    (in_stb3),
      .in_ack    (in_ack3),
      .out_data  (out_data3),
      .out_stb   (out_stb3),
      .out_ack   (out_ack3),
      .out_grant (out_grant3),
      .dbg_state (dbg_state3)
   );

   // ---------------- scoreboard state ----------------
   int vectors     = 0;
   int miscompares = 0;
   logic [33:0] exp_q[$];   // {grant, data}, N=4 instance
   logic [33:0] exp3_q[$];  // {grant, data}, N=3 instance
   int rem[4];
   int rem3[3];
   int ack_cnt[4];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // One clock: capture pre-edge handshakes, advance producers, score output words.
   task automatic step();
      logic [3:0]  hs;
      logic [2:0]  hs3;
      logic        ohs, ohs3, r;
      logic [33:0] ow, ow3;
      hs   = in_stb & in_ack;
      hs3  = in_stb3 & in_ack3;
      ohs  = out_stb & out_ack;
      ohs3 = out_stb3 & out_ack3;
      ow   = {out_grant, out_data};
      ow3  = {out_grant3, out_data3};
      r    = rst;
      for (int i = 0; i < 4; i++) if (in_ack[i]) ack_cnt[i]++;
      @(posedge clk);
      #1;
      if (!r) begin
         for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
               rem[i]--;
               if (rem[i] <= 0) in_stb[i] = 1'b0;
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (hs3[i]) begin
               rem3[i]--;
               if (rem3[i] <= 0) in_stb3[i] = 1'b0;
            end
         end
         if (ohs) begin
            chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("sb_word", 64'(ow), 64'(exp_q.pop_front()));
         end
         if (ohs3) begin
            chk("sb3_pending", 64'(exp3_q.size() != 0), 64'd1);
            if (exp3_q.size() != 0) chk("sb3_word", 64'(ow3), 64'(exp3_q.pop_front()));
         end
      end
   endtask

   task automatic offer(input int i, input int n, input logic [31:0] d);
      rem[i] = n;
      in_data[i*32 +: 32] = d;
      in_stb[i] = 1'b1;
   endtask

   task automatic offer3(input int i, input int n, input logic [31:0] d);
      rem3[i] = n;
      in_data3[i*32 +: 32] = d;
      in_stb3[i] = 1'b1;
   endtask

   task automatic expect_word(input int g, input logic [31:0] d);
      exp_q.push_back({2'(g), d});
   endtask

   task automatic do_reset();
      in_stb  = '0;
      in_stb3 = '0;
      for (int i = 0; i < 4; i++) rem[i] = 0;
      for (int i = 0; i < 3; i++) rem3[i] = 0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      for (int k = 0; k < budget && exp_q.size() != 0; k++) step();
      chk(tag, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic drain3(input string tag, input int budget);
      for (int k = 0; k < budget && exp3_q.size() != 0; k++) step();
      chk(tag, 64'(exp3_q.size()), 64'd0);
   endtask

   task automatic wait_ostb(input string tag);
      for (int k = 0; k < 20 && !out_stb; k++) step();
      chk(tag, 64'(out_stb), 64'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst      = 1'b1;
      in_data  = '0;
      in_stb   = '0;
      out_ack  = 1'b0;
      in_data3 = '0;
      in_stb3  = '0;
      out_ack3 = 1'b0;
      for (int i = 0; i < 4; i++) begin rem[i] = 0; ack_cnt[i] = 0; end
      for (int i = 0; i < 3; i++) rem3[i] = 0;

      // Reset values
      do_reset();
      chk("rst_in_ack",    64'(in_ack),    64'd0);
      chk("rst_out_stb",   64'(out_stb),   64'd0);
      chk("rst_out_data",  64'(out_data),  64'd0);
      chk("rst_out_grant", 64'(out_grant), 64'd0);
      chk("rst_state",     64'(dbg_state), 64'd0);
      chk("rst3_out_stb",  64'(out_stb3),  64'd0);

      // Single word latency: ack at cycle 1, output at cycle 2, idle at cycle 3
      offer(0, 1, 32'h0000_00AA);
      out_ack = 1'b1;
      expect_word(0, 32'h0000_00AA);
      step();
      chk("t1_c1_in_ack",  64'(in_ack),  64'b0001);
      chk("t1_c1_out_stb", 64'(out_stb), 64'd0);
      step();
      chk("t1_c2_out_stb",   64'(out_stb),   64'd1);
      chk("t1_c2_out_data",  64'(out_data),  64'hAA);
      chk("t1_c2_out_grant", 64'(out_grant), 64'd0);
      chk("t1_c2_in_ack",    64'(in_ack),    64'd0);
      step();
      chk("t1_c3_out_stb", 64'(out_stb), 64'd0);
      chk("t1_c3_sb",      64'(exp_q.size()), 64'd0);

      // All four requesters active, two words each
      do_reset();
      for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
      out_ack = 1'b1;
      for (int i = 0; i < 4; i++) offer(i, 2, 32'h10 + i);
`ifdef STREAM_ARB_BURST_EN
      for (int i = 0; i < 4; i++) for (int p = 0; p < 2; p++) expect_word(i, 32'h10 + i);
`else
      for (int p = 0; p < 2; p++) for (int i = 0; i < 4; i++) expect_word(i, 32'h10 + i);
`endif
      drain("t2_drain", 100);
      for (int i = 0; i < 4; i++) chk($sformatf("t2_ack_cnt%0d", i), 64'(ack_cnt[i]), 64'd2);

      // Backpressure while requester 2 owns the output
      out_ack = 1'b0;
      offer(2, 1, 32'h12);
      expect_word(2, 32'h12);
      wait_ostb("t3_granted");
      chk("t3_state_send", 64'(dbg_state), 64'd2);
      offer(3, 1, 32'h13);
      offer(0, 1, 32'h10);
      expect_word(3, 32'h13);
      expect_word(0, 32'h10);
      for (int k = 0; k < 10; k++) begin
         step();
         chk("t3_hold_stb",   64'(out_stb),   64'd1);
         chk("t3_hold_data",  64'(out_data),  64'h12);
         chk("t3_hold_grant", 64'(out_grant), 64'd2);
         chk("t3_hold_ack",   64'(in_ack),    64'd0);
      end
      out_ack = 1'b1;
      step();
      chk("t3_release_stb", 64'(out_stb), 64'd0);
      step();
      chk("t3_next_grant", 64'(in_ack), 64'b1000);
      drain("t3_drain", 40);

      // Reset while a word sits in SEND
      out_ack = 1'b0;
      offer(1, 1, 32'hDEAD_BEEF);
      wait_ostb("t4_granted");
      chk("t4_held_data", 64'(out_data), 64'hDEAD_BEEF);
      offer(0, 1, 32'h10);
      offer(3, 1, 32'h13);
      rst = 1'b1;
      step();
      chk("t4_rst_out_stb", 64'(out_stb), 64'd0);
      chk("t4_rst_in_ack",  64'(in_ack),  64'd0);
      chk("t4_rst_data",    64'(out_data), 64'd0);
      step();
      chk("t4_rst2_in_ack", 64'(in_ack),  64'd0);
      rst = 1'b0;
      out_ack = 1'b1;
      expect_word(0, 32'h10);
      expect_word(3, 32'h13);
      step();
      chk("t4_first_winner", 64'(in_ack), 64'b0001);
      drain("t4_drain", 40);

      // N=3, only requester 2 active for five words, then wrap to requester 0
      out_ack3 = 1'b1;
      offer3(2, 5, 32'h55);
      for (int k = 0; k < 5; k++) exp3_q.push_back({2'd2, 32'h55});
      drain3("t5_drain", 60);
      chk("t5_stb_dropped", 64'(in_stb3), 64'd0);
      offer3(0, 1, 32'h50);
      offer3(2, 1, 32'h55);
      exp3_q.push_back({2'd0, 32'h50});
      exp3_q.push_back({2'd2, 32'h55});
      drain3("t5_wrap_drain", 40);

`ifdef STREAM_ARB_BURST_EN
      // Bursts of four with requesters 0 and 1 continuously active
      do_reset();
      out_ack = 1'b1;
      offer(0, 50, 32'h10);
      offer(1, 50, 32'h11);
      for (int k = 0; k < 4; k++) expect_word(0, 32'h10);
      for (int k = 0; k < 4; k++) expect_word(1, 32'h11);
      expect_word(0, 32'h10);
      drain("t6_drain", 100);
      do_reset();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
